// File: rtl/lcd_hd44780_write_controller.sv
// Write-only HD44780 sequencer (8-bit bus): power-on wait, fixed init commands, then
// host command/data writes over valid/ready, with E strobe and execution waits from clk_mhz.
module lcd_hd44780_write_controller #(
  parameter int unsigned clk_mhz     = 50,
  parameter int unsigned power_on_us = 15000,
  parameter int unsigned exec_us     = 40,
  parameter int unsigned clear_us    = 1640
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_d
);

  localparam int unsigned T1   = clk_mhz;
  localparam int unsigned TE   = exec_us * clk_mhz;
  localparam int unsigned TC   = clear_us * clk_mhz;
  localparam int unsigned TP   = power_on_us * clk_mhz;
  localparam int unsigned MaxA = (T1 > TE) ? T1 : TE;
  localparam int unsigned MaxB = (TC > TP) ? TC : TP;
  localparam int unsigned MaxT = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW = $clog2(MaxT + 1);

  // Counter is loaded with duration-1 on state entry; the state exits when it reads zero.
  localparam logic [CntW-1:0] T1Load = CntW'(T1 - 1);
  localparam logic [CntW-1:0] TeLoad = CntW'(TE - 1);
  localparam logic [CntW-1:0] TcLoad = CntW'(TC - 1);
  localparam logic [CntW-1:0] TpLoad = CntW'(TP - 1);

  localparam logic [2:0] LastIdx = 3'd5;

  typedef enum logic [2:0] {
    StPowerWait,
    StLoad,
    StSetup,
    StPulse,
    StHold,
    StExec,
    StIdle
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      idx_q;
  logic            is_clear;

  function automatic logic [7:0] init_rom(input logic [2:0] i);
    case (i)
      3'd0, 3'd1, 3'd2: init_rom = 8'h38;
      3'd3:             init_rom = 8'h0C;
      3'd4:             init_rom = 8'h01;
      default:          init_rom = 8'h06;
    endcase
  endfunction

  // Clear Display / Return Home need the long execution wait.
  assign is_clear  = !lcd_rs && (lcd_d[7:2] == 6'd0) && (lcd_d[1:0] != 2'd0);
  assign req_ready = (state_q == StIdle);
  assign lcd_rw    = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StPowerWait;
      cnt_q     <= TpLoad;
      idx_q     <= 3'd0;
      init_done <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_e     <= 1'b0;
      lcd_d     <= 8'h00;
    end else begin
      case (state_q)
        StPowerWait: begin
          if (cnt_q == '0) begin
            state_q <= StLoad;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StLoad: begin
          lcd_rs  <= 1'b0;
          lcd_d   <= init_rom(idx_q);
          cnt_q   <= T1Load;
          state_q <= StSetup;
        end
        StSetup: begin
          if (cnt_q == '0) begin
            lcd_e   <= 1'b1;
            cnt_q   <= T1Load;
            state_q <= StPulse;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StPulse: begin
          if (cnt_q == '0) begin
            lcd_e   <= 1'b0;
            cnt_q   <= T1Load;
            state_q <= StHold;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StHold: begin
          if (cnt_q == '0) begin
            cnt_q   <= is_clear ? TcLoad : TeLoad;
            state_q <= StExec;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StExec: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
          end else if (init_done) begin
            state_q <= StIdle;
          end else if (idx_q < LastIdx) begin
            idx_q   <= idx_q + 3'd1;
            state_q <= StLoad;
          end else begin
            init_done <= 1'b1;
            state_q   <= StIdle;
          end
        end
        StIdle: begin
          if (req_valid) begin
            lcd_rs  <= req_rs;
            lcd_d   <= req_data;
            cnt_q   <= T1Load;
            state_q <= StSetup;
          end
        end
        default: begin
          state_q <= StPowerWait;
          cnt_q   <= TpLoad;
          idx_q   <= 3'd0;
        end
      endcase
    end
  end

endmodule
